// File: rtl/h264_bitstream_pkg.sv
// rtl/h264_bitstream_pkg.sv - shared widths, marker encodings and FSM states for the bitstream arbiter
package h264_bitstream_pkg;

  localparam int VE_W      = 25;
  localparam int VL_W      = 5;
  localparam int ALIGN_BIT = 16;
  localparam int DONE_BIT  = 17;

  // Markers travel with VL=0 so the packer decodes bits 16/17 as align/done.
  localparam logic [VE_W-1:0] MARK_ALIGN_VE = VE_W'(1) << ALIGN_BIT;
  localparam logic [VE_W-1:0] MARK_DONE_VE  = MARK_ALIGN_VE | (VE_W'(1) << DONE_BIT);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ALIGN,
    FIN
  } arb_state_e;

endpackage

// File: rtl/h264_grant_picker.sv
// rtl/h264_grant_picker.sv - combinational one-hot winner selection
// H264_ARB_ROUND_ROBIN_EN selects a pointer-based rotating search instead of fixed priority.
module h264_grant_picker #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req_i,
`ifdef H264_ARB_ROUND_ROBIN_EN
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [$clog2(NREQ)-1:0] win_idx_o,
`endif
  output logic [NREQ-1:0]         gnt_o
);

`ifdef H264_ARB_ROUND_ROBIN_EN
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o     = '0;
    win_idx_o = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_idx_o  = idx;
      end
    end
  end
`else
  // Isolate the lowest set bit: index 0 wins.
  assign gnt_o = req_i & (~req_i + NREQ'(1));
`endif

endmodule

// File: rtl/h264_bitstream_arbiter.sv
// rtl/h264_bitstream_arbiter.sv - unit-granular arbiter feeding the (VE, VL) bit-packer
// H264_ARB_ROUND_ROBIN_EN enables round-robin granting; default is fixed priority.
module h264_bitstream_arbiter #(
  parameter int NREQ = 3,
  parameter int VE_W = 25,
  parameter int VL_W = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      req_align_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*VE_W-1:0] req_ve_i,
  input  logic [NREQ*VL_W-1:0] req_vl_i,
  input  logic [NREQ-1:0]      req_last_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [NREQ-1:0]      gnt_o,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  output logic [VE_W-1:0]      out_ve_o,
  output logic [VL_W-1:0]      out_vl_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic                 flush_done_o
);

  import h264_bitstream_pkg::*;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, pick;
  logic            align_pend_q, align_pend_d;
  logic            flush_pend_q, flush_pend_d, flush_prev_q;
  logic            out_valid_q, out_valid_d;
  logic [VE_W-1:0] out_ve_q, out_ve_d, sel_ve;
  logic [VL_W-1:0] out_vl_q, out_vl_d, sel_vl;
  logic            flush_done_q, flush_done_d;
  logic            sel_last, accept;

`ifdef H264_ARB_ROUND_ROBIN_EN
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr_q, ptr_d, win_idx;
`endif

  h264_grant_picker #(.NREQ(NREQ)) u_picker (
    .req_i     (req_i),
`ifdef H264_ARB_ROUND_ROBIN_EN
    .ptr_i     (ptr_q),
    .win_idx_o (win_idx),
`endif
    .gnt_o     (pick)
  );

  assign req_ready_o = (state_q == XFER) ? (gnt_q & {NREQ{out_ready_i}}) : '0;
  assign accept      = |(req_valid_i & req_ready_o);

  always_comb begin
    sel_ve   = '0;
    sel_vl   = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        sel_ve   = req_ve_i[i*VE_W +: VE_W];
        sel_vl   = req_vl_i[i*VL_W +: VL_W];
        sel_last = req_last_i[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    align_pend_d = align_pend_q;
    out_valid_d  = 1'b0;
    out_ve_d     = out_ve_q;
    out_vl_d     = out_vl_q;
    flush_done_d = 1'b0;
    flush_pend_d = flush_pend_q | (flush_i & ~flush_prev_q);
`ifdef H264_ARB_ROUND_ROBIN_EN
    ptr_d        = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d        = pick;
          align_pend_d = |(req_align_i & pick);
          state_d      = XFER;
`ifdef H264_ARB_ROUND_ROBIN_EN
          ptr_d        = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
`endif
        end else if (flush_pend_q) begin
          state_d = FIN;
        end
      end
      XFER: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_ve_d    = sel_ve;
          out_vl_d    = sel_vl;
          if (sel_last) begin
            gnt_d   = '0;
            state_d = align_pend_q ? ALIGN : IDLE;
          end
        end
      end
      ALIGN: begin
        if (out_ready_i) begin
          out_valid_d = 1'b1;
          out_ve_d    = VE_W'(MARK_ALIGN_VE);
          out_vl_d    = '0;
          state_d     = IDLE;
        end
      end
      FIN: begin
        if (out_ready_i) begin
          out_valid_d  = 1'b1;
          out_ve_d     = VE_W'(MARK_DONE_VE);
          out_vl_d     = '0;
          flush_done_d = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      align_pend_q <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_prev_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ve_q     <= '0;
      out_vl_q     <= '0;
      flush_done_q <= 1'b0;
`ifdef H264_ARB_ROUND_ROBIN_EN
      ptr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      align_pend_q <= align_pend_d;
      flush_pend_q <= flush_pend_d;
      flush_prev_q <= flush_i;
      out_valid_q  <= out_valid_d;
      out_ve_q     <= out_ve_d;
      out_vl_q     <= out_vl_d;
      flush_done_q <= flush_done_d;
`ifdef H264_ARB_ROUND_ROBIN_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign gnt_o        = gnt_q;
  assign out_valid_o  = out_valid_q;
  assign out_ve_o     = out_ve_q;
  assign out_vl_o     = out_vl_q;
  assign flush_done_o = flush_done_q;
  assign busy_o       = (state_q != IDLE);

  // A granted requester must hold REQ until its LAST word is taken.
  req_held_during_unit: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_q == XFER) |-> |(req_i & gnt_q));

endmodule

// File: tb/tb_h264_bitstream_arbiter.sv
// tb/tb_h264_bitstream_arbiter.sv - randomized directed bench with a unit-level output stream model
module tb_h264_bitstream_arbiter;
  localparam int NREQ  = 3;
  localparam int VE_W  = 25;
  localparam int VL_W  = 5;
  localparam int DEPTH = 128;
  localparam logic [VE_W-1:0] MARK_ALIGN = 25'h10000;
  localparam logic [VE_W-1:0] MARK_DONE  = 25'h30000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req, req_align, req_valid, req_last, req_ready, gnt;
  logic [NREQ*VE_W-1:0] req_ve;
  logic [NREQ*VL_W-1:0] req_vl;
  logic                 flush, out_valid, out_ready, busy, flush_done;
  logic [VE_W-1:0]      out_ve;
  logic [VL_W-1:0]      out_vl;

  h264_bitstream_arbiter #(.NREQ(NREQ), .VE_W(VE_W), .VL_W(VL_W)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .req_i        (req),
    .req_align_i  (req_align),
    .req_valid_i  (req_valid),
    .req_ve_i     (req_ve),
    .req_vl_i     (req_vl),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .gnt_o        (gnt),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_ve_o     (out_ve),
    .out_vl_o     (out_vl),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .flush_done_o (flush_done)
  );

  int checks = 0;
  int errors = 0;

  // Requester word store: {align, last, ve, vl}; head = next to send, ecur = next to expect.
  logic [31:0]     mem [NREQ][DEPTH];
  int              head [NREQ];
  int              tail [NREQ];
  int              ecur [NREQ];
  logic [29:0]     got[$];
  logic [29:0]     exp_q[$];
  logic [NREQ-1:0] gnt_log[$];
  logic [NREQ-1:0] exp_gnt[$];
  int              gcur = 0;
  int              gncur = 0;
  logic [NREQ-1:0] acc = '0;
  logic [NREQ-1:0] prev_gnt = '0;
  logic            prev_acc = 1'b0;
  int              rdy_mode = 0;
  int              n;
  int              order [6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_unit(input int i, input int len, input logic align);
    logic [VE_W-1:0] ve;
    logic [VL_W-1:0] vl;
    for (int k = 0; k < len; k++) begin
      ve = VE_W'($urandom);
      vl = VL_W'($urandom_range(1, 24));
      mem[i][tail[i]] = {align, (k == len - 1), ve, vl};
      tail[i]++;
    end
  endtask

  task automatic expect_unit(input int i);
    logic [31:0] w;
    do begin
      w = mem[i][ecur[i]];
      exp_q.push_back(w[29:0]);
      ecur[i]++;
    end while (!w[30] && ecur[i] < tail[i]);
    if (w[31]) exp_q.push_back({MARK_ALIGN, 5'd0});
    exp_gnt.push_back(NREQ'(1) << i);
  endtask

  task automatic drive();
    logic [31:0] w;
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] != tail[i]) begin
        w = mem[i][head[i]];
        req[i]                 = 1'b1;
        req_align[i]           = w[31];
        req_last[i]            = w[30];
        req_ve[i*VE_W +: VE_W] = w[29:5];
        req_vl[i*VL_W +: VL_W] = w[4:0];
        req_valid[i]           = ($urandom_range(0, 3) != 0);
      end else begin
        req[i]                 = 1'b0;
        req_align[i]           = 1'b0;
        req_last[i]            = 1'b0;
        req_ve[i*VE_W +: VE_W] = '0;
        req_vl[i*VL_W +: VL_W] = '0;
        req_valid[i]           = 1'b0;
      end
    end
  endtask

  // One clock: observe outputs at the falling edge, retire accepted words, drive the next cycle.
  task automatic tick();
    @(negedge clk);
    if (!reset_n) begin
      prev_acc = 1'b0;
      prev_gnt = '0;
      for (int i = 0; i < NREQ; i++) head[i] = tail[i];
    end else begin
      if (out_valid) got.push_back({out_ve, out_vl});
      if (out_valid && out_vl != 0) chk("word_without_accept", {63'd0, prev_acc}, 64'd1);
      if (prev_acc) chk("valid_after_accept", {63'd0, out_valid}, 64'd1);
      if (gnt != '0 && prev_gnt == '0) gnt_log.push_back(gnt);
      prev_gnt = gnt;
      for (int i = 0; i < NREQ; i++) if (acc[i]) head[i]++;
    end
    drive();
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    #1;
    acc      = reset_n ? (req_valid & req_ready) : '0;
    prev_acc = |acc;
  endtask

  function automatic logic quiet();
    logic q;
    q = !busy;
    for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) q = 1'b0;
    return q;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while (!(quiet() && (got.size() - gcur) >= exp_q.size()) && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_timeout"}, {63'd0, (c < budget)}, 64'd1);
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 64'(got.size() - gcur), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (gcur + k < got.size()) chk({tag, "_word"}, 64'(got[gcur + k]), 64'(exp_q[k]));
    gcur = got.size();
    exp_q.delete();
    chk({tag, "_grants"}, 64'(gnt_log.size() - gncur), 64'(exp_gnt.size()));
    for (int k = 0; k < exp_gnt.size(); k++)
      if (gncur + k < gnt_log.size()) chk({tag, "_gnt_order"}, 64'(gnt_log[gncur + k]), 64'(exp_gnt[k]));
    gncur = gnt_log.size();
    exp_gnt.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      ecur[i] = 0;
    end
    drive();
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ve", 64'(out_ve), 64'd0);
    chk("rst_out_vl", 64'(out_vl), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
    tick();

    // Two simultaneous requesters: lower index first, then the aligned unit.
    add_unit(0, 3, 1'b0);
    add_unit(1, 2, 1'b1);
    expect_unit(0);
    expect_unit(1);
    tick();
    tick();
    chk("first_gnt", 64'(gnt), 64'b001);
    wait_done("fixed", 200);
    check_stream("fixed");

    // Packer back-pressure mid-unit.
    add_unit(1, 6, 1'b0);
    expect_unit(1);
    repeat (3) tick();
    rdy_mode = 2;
    tick();
    chk("stall_ready0", 64'(req_ready), 64'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd0);
    end
    chk("stall_gnt_held", 64'(gnt), 64'b010);
    rdy_mode = 1;
    wait_done("stall", 400);
    check_stream("stall");

    // Reset in the middle of a transfer abandons the unit.
    rdy_mode = 0;
    add_unit(2, 8, 1'b0);
    repeat (4) tick();
    chk("pre_reset_gnt", 64'(gnt), 64'b100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    ecur[2] = tail[2];
    repeat (2) tick();
    reset_n = 1'b1;
    gcur  = got.size();
    gncur = gnt_log.size();
    add_unit(2, 3, 1'b0);
    expect_unit(2);
    tick();
    tick();
    chk("post_reset_gnt", 64'(gnt), 64'b100);
    wait_done("post_reset", 200);
    check_stream("post_reset");

    // Every requester holds two units back to back.
    rdy_mode = 1;
    for (int r = 0; r < NREQ; r++) begin
      add_unit(r, (r == 1) ? 1 : $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      add_unit(r, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end
`ifdef H264_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 2, 0, 1, 2};
`else
    order = '{0, 0, 1, 1, 2, 2};
`endif
    for (int k = 0; k < 6; k++) expect_unit(order[k]);
    wait_done("all_req", 800);
    check_stream("all_req");

    // Flush during a unit; a later request still goes before the done marker.
    rdy_mode = 0;
    add_unit(2, 8, 1'b0);
    expect_unit(2);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    add_unit(0, 2, 1'b1);
    expect_unit(0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.push_back({MARK_DONE, 5'd0});
    n = 0;
    while (!flush_done && n < 300) begin
      tick();
      n++;
    end
    chk("flush_done_seen", 64'(flush_done), 64'd1);
    chk("done_valid", 64'(out_valid), 64'd1);
    chk("done_ve", 64'(out_ve), 64'(MARK_DONE));
    chk("done_vl", 64'(out_vl), 64'd0);
    tick();
    chk("flush_done_pulse", 64'(flush_done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    wait_done("flush", 200);
    check_stream("flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/h264_bitstream_arbiter.md
Name: h264_bitstream_arbiter

Overview:
- Shares the single (VE, VL) bit-packer input between NREQ codeword producers: parameter-set writer, slice-header writer, CAVLC residual coder, etc.
- Grants one requester for a whole syntax unit, terminated by a LAST-flagged word.
- Optionally follows each unit with a byte-alignment marker.
- On FLUSH, appends an end-of-stream (align+done) marker.
- Sits directly upstream of the bit-packer and obeys its READY flow control.

Parameters:
- NREQ, 3, number of requesters (2..8); index 0 is highest priority in fixed mode.
- VE_W, 25, codeword value width.
- VL_W, 5, codeword length width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- REQ  in  NREQ  requester i has a unit pending; level, held until its LAST word is accepted.
- REQ_ALIGN  in  NREQ  sampled at grant; 1 = emit an align marker after this unit.
- REQ_VALID  in  NREQ  word valid from requester i.
- REQ_VE  in  NREQ*VE_W  packed codeword values; slice i = [i*VE_W +: VE_W].
- REQ_VL  in  NREQ*VL_W  packed codeword lengths.
- REQ_LAST  in  NREQ  current word is the last of the unit.
- REQ_READY  out  NREQ  word accepted when REQ_VALID[i] & REQ_READY[i]; one-hot or zero.
- GNT  out  NREQ  one-hot grant, held for the whole unit.
- FLUSH  in  1  end-of-stream request; pulse or level, taken once.
- OUT_VALID  out  1  write strobe to the packer; the packer accepts unconditionally.
- OUT_VE  out  VE_W  codeword value to the packer.
- OUT_VL  out  VL_W  codeword length to the packer.
- OUT_READY  in  1  packer has FIFO space (fill < 24).
- BUSY  out  1  FSM is not in IDLE.
- FLUSH_DONE  out  1  one-cycle pulse when the done marker is issued.

Behaviour:
- Reset (asynchronous, RESET_N=0): FSM=IDLE, GNT=0, OUT_VALID=0, OUT_VE=0, OUT_VL=0, FLUSH_DONE=0, pending-flush=0, round-robin pointer=0. REQ_READY is combinational and therefore 0.
- Reset mid-unit: the unit is abandoned and nothing is resent. The requester must restart after reset.
- FSM states: IDLE, XFER, ALIGN, FIN.
- IDLE:
  - If any REQ bit is set: grant the winner (lowest index in fixed mode), latch REQ_ALIGN[winner] into align_pend, go to XFER.
  - Else, if a flush is pending: go to FIN.
  - REQ takes priority over a pending flush.
  - The grant takes one cycle; no word is accepted in IDLE.
- XFER:
  - REQ_READY[g] = OUT_READY; all other REQ_READY bits are 0.
  - Each accepted word is registered: next cycle OUT_VALID=1, OUT_VE/OUT_VL = that word. Latency is 1 cycle.
  - When the accepted word has LAST=1: go to ALIGN if align_pend, else go to IDLE. GNT clears on that same edge.
  - OUT_READY low stalls the transfer and emits no words. The packer's 24-entry threshold absorbs the 1-word pipeline.
- ALIGN:
  - Wait for OUT_READY=1, then issue one marker: OUT_VE=25'h10000 (bit 16), OUT_VL=0.
  - Go to IDLE.
- FIN:
  - Wait for OUT_READY=1, then issue OUT_VE=25'h30000 (bits 16+17), OUT_VL=0.
  - Pulse FLUSH_DONE, clear the pending flush, go to IDLE.
- FLUSH:
  - A rising level (or pulse) sets pending-flush in any state.
  - A second FLUSH while one is pending is absorbed.
- Markers always carry VL=0 (<16), so the packer interprets bits 16/17 as align/done.
- A requester word with VL<16 and VE[16] or VE[17] set is forwarded unchanged. Requesters own that encoding.
- OUT_VALID is never 1 on two consecutive cycles unless each corresponds to a distinct accepted word or marker.
- REQ dropping mid-unit before LAST: the grant is held. This is a protocol violation and is flagged by assertion.
- GNT zero-length unit (LAST on the first word) is legal.

Optional Feature:
- Macro H264_ARB_ROUND_ROBIN_EN.
- Defined: round-robin grant. Search starts at pointer; pointer = winner+1 (mod NREQ) after each grant.
- Undefined: fixed priority, index 0 highest; the pointer register is removed.

Decomposition:
- Package h264_bitstream_pkg holds:
  - VE_W, VL_W.
  - ALIGN_BIT=16, DONE_BIT=17.
  - Constants MARK_ALIGN_VE=25'h10000, MARK_DONE_VE=25'h30000.
  - The arb_state_e enum {IDLE, XFER, ALIGN, FIN}.
- Sub-module h264_grant_picker: combinational one-hot winner from REQ and pointer. Holds both fixed and RR variants under the macro.

Test Plan:
- REQ=3'b011 in IDLE, fixed mode -> GNT=3'b001. Req0 sends 3 words, last LAST=1. OUT_VALID pulses 3 times, 1 cycle after each accept. Then GNT=3'b010.
- Req1 unit with REQ_ALIGN=1, 2 words -> OUT shows 2 words, then VE=25'h10000 VL=0, then IDLE.
- OUT_READY forced 0 for 10 cycles mid-unit -> REQ_READY=0 and OUT_VALID=0 throughout. On resume, no words are lost or duplicated; the word order matches the scoreboard.
- FLUSH pulse during a req2 unit -> unit completes, then VE=25'h30000 VL=0, FLUSH_DONE high for 1 cycle, BUSY low next cycle.
- RESET_N asserted mid-XFER -> OUT_VALID=0, GNT=0, BUSY=0 immediately. After release, REQ=3'b100 is granted normally.
- H264_ARB_ROUND_ROBIN_EN with all REQ held high -> grants cycle in order 0, 1, 2, 0.
